// File: rtl/mux_sched_pkg.sv
// Shared constants, state encoding and small index helpers for the 4-way
// round-robin mux scheduler.
package mux_sched_pkg;

    localparam int N_REQ         = 4;
    localparam int IDX_W         = 2;
    localparam int DEFAULT_WIDTH = 4;
    localparam int BEAT_W        = 4;

    localparam logic [BEAT_W-1:0] BEAT_ZERO = 4'd0;
    localparam logic [BEAT_W-1:0] BEAT_ONE  = 4'd1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Index to one-hot requester mask.
    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = {N_REQ{1'b0}};
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Cyclic successor of a requester index (3 wraps to 0).
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/mux4_rr_scheduler_if.sv
// Requester-side and consumer-side signals of the scheduler bundled together.
// master = producers/consumer environment, slave = the scheduler itself.
interface mux4_rr_scheduler_if #(
    parameter int WIDTH = mux_sched_pkg::DEFAULT_WIDTH
);
    import mux_sched_pkg::*;

    logic [N_REQ-1:0]       in_req;
    logic [N_REQ*WIDTH-1:0] in_data;
    logic [N_REQ-1:0]       in_ack;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_y;
    logic [WIDTH-1:0]       out_y_b;
    logic [IDX_W-1:0]       out_sel;
    logic [N_REQ-1:0]       out_grant;

    modport master (
        output in_req, in_data, out_ready,
        input  in_ack, out_valid, out_y, out_y_b, out_sel, out_grant
    );

    modport slave (
        input  in_req, in_data, out_ready,
        output in_ack, out_valid, out_y, out_y_b, out_sel, out_grant
    );

endinterface

// File: rtl/rr_pick4.sv
// Combinational cyclic priority picker: first set bit of req starting at ptr.
module rr_pick4
    import mux_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    logic [IDX_W-1:0] cand_s;

    // Scan requesters in cyclic order from ptr and latch the first hit.
    always_comb begin
        found  = 1'b0;
        idx    = ptr;
        cand_s = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            cand_s = ptr + IDX_W'(i);
            if (!found && req[cand_s]) begin
                found = 1'b1;
                idx   = cand_s;
            end else begin
                found = found;
            end
        end
    end

    // One-hot form of the pick; all zeros when nothing is requesting.
    always_comb begin
        if (found) begin
            onehot = idx_to_onehot(idx);
        end else begin
            onehot = {N_REQ{1'b0}};
        end
    end

endmodule

// File: rtl/mux4_rr_scheduler.sv
// Round-robin scheduler sharing one 4:1 true/complement mux path among four
// requesters. The chosen slice and its complement are captured into an
// output register stage that is drained with a valid/ready handshake.
// An owner may keep the grant for up to MAX_BURST accepted beats.
module mux4_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_BURST = 1
)
(
    input  logic               clk,
    input  logic               rst_n,
    mux4_rr_scheduler_if.slave bus
);

    localparam logic [BEAT_W-1:0] MAX_BURST_C = BEAT_W'(MAX_BURST);

    // Registered state
    state_e            state_q,    state_d;
    logic [IDX_W-1:0]  rr_ptr_q,   rr_ptr_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [WIDTH-1:0]  y_q,        y_d;
    logic [WIDTH-1:0]  y_b_q,      y_b_d;
    logic [IDX_W-1:0]  sel_q,      sel_d;
    logic [N_REQ-1:0]  grant_q,    grant_d;

    // Decode signals
    logic              pick_found_s;
    logic [IDX_W-1:0]  pick_idx_s;
    logic [N_REQ-1:0]  pick_onehot_s;
    logic              busy_s;
    logic              transfer_s;
    logic              keep_s;
    logic              load_en_s;
    logic [IDX_W-1:0]  src_idx_s;
    logic [N_REQ-1:0]  src_onehot_s;
    logic [WIDTH-1:0]  slice_s;

    rr_pick4 u_pick (
        .req    (bus.in_req),
        .ptr    (rr_ptr_q),
        .found  (pick_found_s),
        .idx    (pick_idx_s),
        .onehot (pick_onehot_s)
    );

    // Capture decision: keep the owner while its burst budget lasts, otherwise
    // take the round-robin pick. The owner is only reconsidered at a transfer.
    always_comb begin
        busy_s     = (state_q == ST_BUSY);
        transfer_s = busy_s && bus.out_ready;
        keep_s     = busy_s && bus.in_req[sel_q] && (beat_cnt_q < MAX_BURST_C);
        if (busy_s) begin
            load_en_s = transfer_s && pick_found_s;
        end else begin
            load_en_s = pick_found_s;
        end
        if (keep_s) begin
            src_idx_s    = sel_q;
            src_onehot_s = grant_q;
        end else begin
            src_idx_s    = pick_idx_s;
            src_onehot_s = pick_onehot_s;
        end
    end

    // 4:1 data select steered by the chosen source index.
    always_comb begin
        slice_s = bus.in_data[int'(src_idx_s)*WIDTH +: WIDTH];
    end

    // Next-state and next-output computation for the two-state controller.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        y_d        = y_q;
        y_b_d      = y_b_q;
        sel_d      = sel_q;
        grant_d    = grant_q;
        case (state_q)
            ST_IDLE, ST_BUSY: begin
                if (load_en_s) begin
                    state_d = ST_BUSY;
                    y_d     = slice_s;
                    y_b_d   = ~slice_s;
                    sel_d   = src_idx_s;
                    grant_d = src_onehot_s;
                    if (keep_s) begin
                        beat_cnt_d = beat_cnt_q + BEAT_ONE;
                    end else begin
                        beat_cnt_d = BEAT_ONE;
                        rr_ptr_d   = idx_inc(pick_idx_s);
                    end
                end else if (transfer_s) begin
                    // Drain: nothing pending, last word/select are kept.
                    state_d    = ST_IDLE;
                    grant_d    = {N_REQ{1'b0}};
                    beat_cnt_d = BEAT_ZERO;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = {N_REQ{1'b0}};
                beat_cnt_d = BEAT_ZERO;
            end
        endcase
    end

    // State and output register stage with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= 2'd0;
            beat_cnt_q <= BEAT_ZERO;
            y_q        <= {WIDTH{1'b0}};
            y_b_q      <= {WIDTH{1'b1}};
            sel_q      <= 2'd0;
            grant_q    <= {N_REQ{1'b0}};
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            y_q        <= y_d;
            y_b_q      <= y_b_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
        end
    end

    // Ack pulses on the capture cycle only; forced low while reset is held.
    always_comb begin
        if (load_en_s && rst_n) begin
            bus.in_ack = src_onehot_s;
        end else begin
            bus.in_ack = {N_REQ{1'b0}};
        end
    end

    assign bus.out_valid = (state_q == ST_BUSY);
    assign bus.out_y     = y_q;
    assign bus.out_y_b   = y_b_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_grant = grant_q;

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Directed bench for mux4_rr_scheduler: instance A uses MAX_BURST=1,
// instance B uses MAX_BURST=2. Both share clock and reset.
module tb_mux4_rr_scheduler;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mux4_rr_scheduler_if #(.WIDTH(4)) ia ();
    mux4_rr_scheduler_if #(.WIDTH(4)) ib ();

    mux4_rr_scheduler #(.WIDTH(4), .MAX_BURST(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia)
    );

    mux4_rr_scheduler #(.WIDTH(4), .MAX_BURST(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Registered output checks on instance A.
    task automatic chk_a(input string tag, input logic v, input logic [1:0] s,
                         input logic [3:0] y, input logic [3:0] g);
        logic [3:0] yb;
        yb = ~y;
        chk({tag, "_valid"}, 32'(ia.out_valid), 32'(v));
        chk({tag, "_sel"},   32'(ia.out_sel),   32'(s));
        chk({tag, "_y"},     32'(ia.out_y),     32'(y));
        chk({tag, "_y_b"},   32'(ia.out_y_b),   32'(yb));
        chk({tag, "_grant"}, 32'(ia.out_grant), 32'(g));
    endtask

    initial begin
        logic [1:0] exp_sel3 [5];
        logic [1:0] exp_sel5 [6];
        logic [3:0] oh;
        logic [3:0] yv;

        checks   = 0;
        failures = 0;
        exp_sel3 = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        exp_sel5 = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0};

        rst_n        = 1'b0;
        ia.in_req    = 4'b0000;
        ia.in_data   = 16'h0000;
        ia.out_ready = 1'b0;
        ib.in_req    = 4'b0000;
        ib.in_data   = 16'h0000;
        ib.out_ready = 1'b0;

        // 1: reset values
        #12;
        chk_a("rst", 1'b0, 2'd0, 4'h0, 4'b0000);
        chk("rst_ack", 32'(ia.in_ack), 32'h0);
        chk("rst_b_valid", 32'(ib.out_valid), 32'h0);
        rst_n = 1'b1;
        tick();

        // 2: single request from b
        ia.in_req    = 4'b0010;
        ia.in_data   = 16'h0050;
        ia.out_ready = 1'b1;
        #1;
        chk("t2_ack", 32'(ia.in_ack), 32'h2);
        tick();
        chk_a("t2", 1'b1, 2'd1, 4'h5, 4'b0010);
        ia.in_req = 4'b0000;
        #1;
        chk("t2_drain_ack", 32'(ia.in_ack), 32'h0);
        tick();
        chk_a("t2_drain", 1'b0, 2'd1, 4'h5, 4'b0000);

        // 3: all four requesting, pointer resumes after b -> c,d,a,b,c
        ia.in_req  = 4'b1111;
        ia.in_data = 16'hDCBA;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << exp_sel3[k];
            yv = 4'hA + 4'(exp_sel3[k]);
            #1;
            chk($sformatf("t3_ack%0d", k), 32'(ia.in_ack), 32'(oh));
            tick();
            chk_a($sformatf("t3_beat%0d", k), 1'b1, exp_sel3[k], yv, oh);
        end

        // 4: backpressure for three clocks, then d is taken
        ia.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t4_ack%0d", k), 32'(ia.in_ack), 32'h0);
            tick();
            chk_a($sformatf("t4_hold%0d", k), 1'b1, 2'd2, 4'hC, 4'b0100);
        end
        ia.out_ready = 1'b1;
        #1;
        chk("t4_release_ack", 32'(ia.in_ack), 32'h8);
        tick();
        chk_a("t4_release", 1'b1, 2'd3, 4'hD, 4'b1000);
        ia.in_req = 4'b0000;
        tick();
        chk_a("t4_drain", 1'b0, 2'd3, 4'hD, 4'b0000);

        // 5: MAX_BURST=2 on instance B, a and c requesting
        ib.in_req    = 4'b0101;
        ib.in_data   = 16'h0301;
        ib.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            oh = 4'b0001 << exp_sel5[k];
            yv = (exp_sel5[k] == 2'd0) ? 4'h1 : 4'h3;
            #1;
            chk($sformatf("t5_ack%0d", k), 32'(ib.in_ack), 32'(oh));
            tick();
            chk($sformatf("t5_sel%0d", k), 32'(ib.out_sel), 32'(exp_sel5[k]));
            chk($sformatf("t5_y%0d", k), 32'(ib.out_y), 32'(yv));
        end
        ib.in_req = 4'b0000;
        tick();
        chk("t5_drain_valid", 32'(ib.out_valid), 32'h0);

        // 6: reset in the middle of a burst on instance A
        ia.in_req  = 4'b1100;
        ia.in_data = 16'hDCBA;
        #1;
        chk("t6_ack", 32'(ia.in_ack), 32'h4);
        tick();
        chk_a("t6_busy", 1'b1, 2'd2, 4'hC, 4'b0100);
        ia.out_ready = 1'b0;
        ia.in_req    = 4'b1110;
        #2;
        rst_n = 1'b0;
        #1;
        chk_a("t6_rst", 1'b0, 2'd0, 4'h0, 4'b0000);
        chk("t6_rst_ack", 32'(ia.in_ack), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("t6_restart_ack", 32'(ia.in_ack), 32'h2);
        tick();
        chk_a("t6_restart", 1'b1, 2'd1, 4'hB, 4'b0010);
        ia.in_req    = 4'b0000;
        ia.out_ready = 1'b1;
        tick();
        chk("t6_drain_valid", 32'(ia.out_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
